pheap_level_ctl: RTL and testbench
==================================

# pheap_level_ctl

Parametrised per-level controller for the pipelined heap (pheap) priority queue, covering every level from 2 down to the leaf level. Each operation reads the level's top entry and the two child entries from the level's SRAM, updates the top entry, and tells the next level what to do. Over the fixed-width, enqueue/dequeue-only level controller it adds generic data and capacity widths, a configurable read latency, a leaf-level mode, a REPLACE operation, explicit full/empty errors and back-to-back issue.

## Interface
Parameters:
- LEVEL, 2: heap level served; must be ≥2. Top address width is LEVEL-1 bits; child address width is LEVEL bits.
- DATA_W, 32: priority value width, unsigned.
- CAP_W, 8: width of the free-slot count held in each entry.
- RD_LAT, 1: SRAM read latency in cycles, 1..3.
- LEAF, 0: when 1, this is the last level; child data is ignored and treated as inactive with capacity 0.

Ports:
- clk, in, 1: clock; all state changes on the rising edge.
- rst_n, in, 1: asynchronous, active-low reset.
- start, in, 1: operation request; accepted when ready=1.
- ready, out, 1: high in IDLE and EXEC.
- op, in, 2: 0=NOP, 1=ENQ, 2=DEQ, 3=REPL.
- start_pos, in, LEVEL-1: top-entry address at this level.
- in_val, in, DATA_W: value to insert or replace with.
- raddr_top, out, LEVEL-1: top read address.
- raddr_bot, out, LEVEL: left-child address {pos,0}; the right child is {pos,1}.
- r_top, r_bot_l, r_bot_r, in, 1+CAP_W+DATA_W: SRAM read entries {active, capacity, value}.
- wen_top, out, 1: top write enable.
- waddr_top, out, LEVEL-1: top write address.
- wdata, out, 1+CAP_W+DATA_W: entry written to the top.
- done_vld, out, 1: one-cycle result strobe.
- done_code, out, 2: 0=DONE, 1=NEXT_LEVEL, 2=ERR_FULL, 3=ERR_EMPTY.
- next_op, out, 2: operation passed to the next level.
- next_pos, out, LEVEL: child address for the next level.
- next_val, out, DATA_W: value carried down to the next level.
- out_val, out, DATA_W: value ejected from this level (the dequeued or displaced value).

## Operation
- Heap ordering: max-heap; larger values sit nearer the root. All comparisons are unsigned.
- Free-slot count: capacity = free slots in the subtree rooted at this entry.
- Capture: start is sampled when ready=1, together with op, start_pos and in_val. start with op=NOP is ignored.
- State machine: IDLE → RD on accepted start. RD lasts RD_LAT cycles (down-counter) → EXEC. EXEC lasts one cycle → IDLE, or → RD if a new start is accepted in EXEC.
- Read addresses: raddr_top and raddr_bot come from the captured start_pos during RD.
- Child selection for ENQ: the child with the larger capacity; tie goes left. The selected child must have capacity >0.
- Child selection for DEQ and REPL: the larger active child; tie goes left. An inactive child never wins.

All EXEC actions below are taken from the captured values:
- ENQ, top inactive: write {1, cap-1, in}; DONE.
- ENQ, top active, cap=0: no write; ERR_FULL.
- ENQ, top active, cap>0:
  - Write {1, cap-1, max(top,in)}.
  - next_val = min(top,in); next_op = ENQ; next_pos = ENQ-selected child; NEXT_LEVEL.
- DEQ, top inactive: no write; out_val = 0; ERR_EMPTY.
- DEQ, top active:
  - out_val = top value; capacity written as cap+1.
  - No active child: write {0, cap+1, 0}; DONE.
  - Otherwise: write {1, cap+1, larger child}; next_op = DEQ; next_pos = that child; NEXT_LEVEL.
- REPL, top inactive: behaves exactly as ENQ.
- REPL, top active:
  - out_val = top value; capacity unchanged.
  - If in ≥ every active child: write {1, cap, in}; DONE.
  - Otherwise: write the larger child's value; next_op = REPL; next_val = in; next_pos = that child; NEXT_LEVEL.
- LEAF=1: always finishes with DONE. ENQ into an active top gives ERR_FULL. DEQ clears the entry.
- Capacity arithmetic: modulo 2^CAP_W, never saturated. cap+1 overflow is a caller error.

## Timing
- Reset values (while rst_n=0): state IDLE; ready 1; wen_top 0; done_vld 0; done_code 0; next_op 0; next_pos, next_val, out_val, wdata 0; waddr_top, raddr_top and raddr_bot 0; capture registers 0.
- Latency: an accepted start at edge t gives EXEC and done_vld during cycle t+RD_LAT (cycles counted after t).
- EXEC cycle: wen_top pulses and all outputs are valid only in this cycle; they are 0 in every other cycle.
- Throughput: one operation per RD_LAT+1 cycles.
- Back-to-back to the same start_pos: RD reads the entry written at the EXEC edge. This relies on a write-then-read SRAM, which the level RAM provides.
- Reset mid-operation: asynchronous abort; no write is issued and state returns to IDLE.

## Test plan
- Enqueue into empty: reset; ENQ in=5 at pos 0, r_top={0,6,0}, RD_LAT=1 → done_vld at t+1 with DONE; wdata={1,5,5}; wen_top=1.
- Enqueue push-down: r_top={1,6,9}, in=12, r_bot_l cap 2, r_bot_r cap 3 → wdata={1,5,12}; next_val=9; next_pos=1; NEXT_LEVEL.
- Full and empty errors: ENQ with r_top={1,0,7} → ERR_FULL, wen_top=0. DEQ with r_top inactive → ERR_EMPTY, out_val=0.
- Dequeue with promotion: r_top={1,0,20}, children 8 and 8 → out_val=20; wdata={1,1,8}; next_pos=0 (tie goes left); next_op=DEQ.
- Replace: r_top={1,2,20}, in=3, children 10 and inactive → out_val=20; wdata={1,2,10}; next_val=3; next_op=REPL. Repeat with in=15 → wdata={1,2,15}; DONE.
- Pipelining and reset: RD_LAT=3 with starts back-to-back in EXEC → done_vld every 4 cycles. Drop rst_n during RD → no wen_top, ready=1 immediately.

Source files
------------

// File: rtl/pheap_level_ctl.sv
// pheap_level_ctl: per-level controller for the pipelined heap priority queue.
// Reads the level's top entry and its two children, rewrites the top entry and
// tells the next level which operation to continue with (ENQ/DEQ/REPL).
module pheap_level_ctl #(
   parameter int LEVEL  = 2,
   parameter int DATA_W = 32,
   parameter int CAP_W  = 8,
   parameter int RD_LAT = 1,
   parameter int LEAF   = 0
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        start,
   output logic                        ready,
   input  logic [1:0]                  op,
   input  logic [LEVEL-2:0]            start_pos,
   input  logic [DATA_W-1:0]           in_val,
   output logic [LEVEL-2:0]            raddr_top,
   output logic [LEVEL-1:0]            raddr_bot,
   input  logic [CAP_W+DATA_W:0]       r_top,
   input  logic [CAP_W+DATA_W:0]       r_bot_l,
   input  logic [CAP_W+DATA_W:0]       r_bot_r,
   output logic                        wen_top,
   output logic [LEVEL-2:0]            waddr_top,
   output logic [CAP_W+DATA_W:0]       wdata,
   output logic                        done_vld,
   output logic [1:0]                  done_code,
   output logic [1:0]                  next_op,
   output logic [LEVEL-1:0]            next_pos,
   output logic [DATA_W-1:0]           next_val,
   output logic [DATA_W-1:0]           out_val
);

   localparam int EW = 1 + CAP_W + DATA_W;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RD   = 2'd1;
   localparam logic [1:0] S_EXEC = 2'd2;

   localparam logic [1:0] OP_NOP  = 2'd0;
   localparam logic [1:0] OP_ENQ  = 2'd1;
   localparam logic [1:0] OP_DEQ  = 2'd2;
   localparam logic [1:0] OP_REPL = 2'd3;

   localparam logic [1:0] C_DONE  = 2'd0;
   localparam logic [1:0] C_NEXT  = 2'd1;
   localparam logic [1:0] C_FULL  = 2'd2;
   localparam logic [1:0] C_EMPTY = 2'd3;

   localparam logic [1:0] CNT_INIT = 2'(RD_LAT - 1);

   logic [1:0]        state;
   logic [1:0]        cnt;
   logic [1:0]        op_q;
   logic [LEVEL-2:0]  pos_q;
   logic [DATA_W-1:0] val_q;
   logic              accept;

   assign ready  = (state == S_IDLE) || (state == S_EXEC);
   assign accept = ready && start && (op != OP_NOP);

   // State machine, read-latency counter and request capture
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
         cnt   <= '0;
         op_q  <= '0;
         pos_q <= '0;
         val_q <= '0;
      end else begin
         case (state)
            S_IDLE:  if (accept) state <= S_RD;
            S_RD:    if (cnt == '0) state <= S_EXEC;
            S_EXEC:  state <= accept ? S_RD : S_IDLE;
            default: state <= S_IDLE;
         endcase
         if (state == S_RD && cnt != '0)
            cnt <= cnt - 2'd1;
         if (accept) begin
            cnt   <= CNT_INIT;
            op_q  <= op;
            pos_q <= start_pos;
            val_q <= in_val;
         end
      end
   end

   assign raddr_top = (state == S_RD) ? pos_q : '0;
   assign raddr_bot = (state == S_RD) ? {pos_q, 1'b0} : '0;

   // Entry field decode; a leaf level sees its children as inactive, capacity 0
   logic              t_act, l_act, r_act, any_act;
   logic [CAP_W-1:0]  t_cap, l_cap, r_cap, cap_dec, cap_inc;
   logic [DATA_W-1:0] t_val, l_val, r_val, big_val;
   logic              enq_sel_r, deq_sel_r;

   assign t_act   = r_top[EW-1];
   assign t_cap   = r_top[EW-2 -: CAP_W];
   assign t_val   = r_top[DATA_W-1:0];
   assign l_act   = (LEAF == 0) && r_bot_l[EW-1];
   assign r_act   = (LEAF == 0) && r_bot_r[EW-1];
   assign l_cap   = (LEAF == 0) ? r_bot_l[EW-2 -: CAP_W] : '0;
   assign r_cap   = (LEAF == 0) ? r_bot_r[EW-2 -: CAP_W] : '0;
   assign l_val   = r_bot_l[DATA_W-1:0];
   assign r_val   = r_bot_r[DATA_W-1:0];
   assign any_act = l_act || r_act;
   assign cap_dec = t_cap - CAP_W'(1);
   assign cap_inc = t_cap + CAP_W'(1);

   // ENQ goes to the roomier child; DEQ/REPL follow the larger active child
   assign enq_sel_r = r_cap > l_cap;
   assign deq_sel_r = r_act && (!l_act || (r_val > l_val));
   assign big_val   = deq_sel_r ? r_val : l_val;

   // EXEC-cycle actions; every output is zero outside EXEC
   always_comb begin
      wen_top   = 1'b0;
      waddr_top = '0;
      wdata     = '0;
      done_vld  = 1'b0;
      done_code = C_DONE;
      next_op   = OP_NOP;
      next_pos  = '0;
      next_val  = '0;
      out_val   = '0;
      if (state == S_EXEC) begin
         done_vld  = 1'b1;
         waddr_top = pos_q;
         // REPL into an empty slot is a plain enqueue
         if (op_q == OP_ENQ || (op_q == OP_REPL && !t_act)) begin
            if (!t_act) begin
               wen_top = 1'b1;
               wdata   = {1'b1, cap_dec, val_q};
            end else if (t_cap == '0 || LEAF != 0) begin
               done_code = C_FULL;
            end else begin
               wen_top   = 1'b1;
               wdata     = {1'b1, cap_dec, (val_q > t_val) ? val_q : t_val};
               next_val  = (val_q > t_val) ? t_val : val_q;
               next_op   = OP_ENQ;
               next_pos  = {pos_q, enq_sel_r};
               done_code = C_NEXT;
            end
         end else if (op_q == OP_DEQ) begin
            if (!t_act) begin
               done_code = C_EMPTY;
            end else begin
               wen_top = 1'b1;
               out_val = t_val;
               if (!any_act) begin
                  wdata = {1'b0, cap_inc, {DATA_W{1'b0}}};
               end else begin
                  wdata     = {1'b1, cap_inc, big_val};
                  next_op   = OP_DEQ;
                  next_pos  = {pos_q, deq_sel_r};
                  done_code = C_NEXT;
               end
            end
         end else begin
            wen_top = 1'b1;
            out_val = t_val;
            if (!any_act || val_q >= big_val) begin
               wdata = {1'b1, t_cap, val_q};
            end else begin
               wdata     = {1'b1, t_cap, big_val};
               next_op   = OP_REPL;
               next_val  = val_q;
               next_pos  = {pos_q, deq_sel_r};
               done_code = C_NEXT;
            end
         end
      end
   end

endmodule

// File: tb/tb_pheap_level_ctl.sv
// Directed bench for pheap_level_ctl: an RD_LAT=1 level, a leaf level sharing
// its stimulus, and an RD_LAT=3 level for back-to-back issue and reset abort.
module tb_pheap_level_ctl;

  localparam int LV = 2;
  localparam int DW = 8;
  localparam int CW = 4;
  localparam int EW = 1 + CW + DW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start1, start3;
  logic [1:0]    op;
  logic [LV-2:0] start_pos;
  logic [DW-1:0] in_val;
  logic [EW-1:0] r_top, r_bot_l, r_bot_r;

  logic          ready1, wen1, done1;
  logic [LV-2:0] rat1, wat1;
  logic [LV-1:0] rab1, npos1;
  logic [EW-1:0] wdata1;
  logic [1:0]    code1, nop1;
  logic [DW-1:0] nval1, oval1;

  logic          readyL, wenL, doneL;
  logic [LV-2:0] ratL, watL;
  logic [LV-1:0] rabL, nposL;
  logic [EW-1:0] wdataL;
  logic [1:0]    codeL, nopL;
  logic [DW-1:0] nvalL, ovalL;

  logic          ready3, wen3, done3;
  logic [LV-2:0] rat3, wat3;
  logic [LV-1:0] rab3, npos3;
  logic [EW-1:0] wdata3;
  logic [1:0]    code3, nop3;
  logic [DW-1:0] nval3, oval3;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pheap_level_ctl #(.LEVEL(LV), .DATA_W(DW), .CAP_W(CW), .RD_LAT(1), .LEAF(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .ready(ready1), .op(op),
    .start_pos(start_pos), .in_val(in_val), .raddr_top(rat1), .raddr_bot(rab1),
    .r_top(r_top), .r_bot_l(r_bot_l), .r_bot_r(r_bot_r), .wen_top(wen1),
    .waddr_top(wat1), .wdata(wdata1), .done_vld(done1), .done_code(code1),
    .next_op(nop1), .next_pos(npos1), .next_val(nval1), .out_val(oval1));

  pheap_level_ctl #(.LEVEL(LV), .DATA_W(DW), .CAP_W(CW), .RD_LAT(1), .LEAF(1)) dutl (
    .clk(clk), .rst_n(rst_n), .start(start1), .ready(readyL), .op(op),
    .start_pos(start_pos), .in_val(in_val), .raddr_top(ratL), .raddr_bot(rabL),
    .r_top(r_top), .r_bot_l(r_bot_l), .r_bot_r(r_bot_r), .wen_top(wenL),
    .waddr_top(watL), .wdata(wdataL), .done_vld(doneL), .done_code(codeL),
    .next_op(nopL), .next_pos(nposL), .next_val(nvalL), .out_val(ovalL));

  pheap_level_ctl #(.LEVEL(LV), .DATA_W(DW), .CAP_W(CW), .RD_LAT(3), .LEAF(0)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .ready(ready3), .op(op),
    .start_pos(start_pos), .in_val(in_val), .raddr_top(rat3), .raddr_bot(rab3),
    .r_top(r_top), .r_bot_l(r_bot_l), .r_bot_r(r_bot_r), .wen_top(wen3),
    .waddr_top(wat3), .wdata(wdata3), .done_vld(done3), .done_code(code3),
    .next_op(nop3), .next_pos(npos3), .next_val(nval3), .out_val(oval3));

  function automatic logic [EW-1:0] ent(input logic a, input logic [CW-1:0] c,
                                        input logic [DW-1:0] v);
    return {a, c, v};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  // Issue one op to the RD_LAT=1 instances; returns at the negedge inside EXEC
  task automatic issue(input logic [1:0] o, input logic [LV-2:0] p, input logic [DW-1:0] v);
    @(negedge clk);
    start1 = 1'b1; op = o; start_pos = p; in_val = v;
    @(negedge clk);
    start1 = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; start1 = 1'b0; start3 = 1'b0; op = 2'd0;
    start_pos = '0; in_val = '0; r_top = '0; r_bot_l = '0; r_bot_r = '0;
    #12;
    chk("rst_ready", ready1, 1'b1);
    chk("rst_done", done1, 1'b0);
    chk("rst_wen", wen1, 1'b0);
    chk("rst_wdata", wdata1, 13'h0);
    chk("rst_raddr_bot", rab1, 2'd0);
    chk("rst_ready3", ready3, 1'b1);
    @(negedge clk); rst_n = 1'b1;

    // Enqueue into an empty slot; also look at the RD cycle
    r_top = ent(1'b0, 4'd6, 8'd0);
    @(negedge clk);
    start1 = 1'b1; op = 2'd1; start_pos = 1'b1; in_val = 8'd5;
    @(negedge clk);
    start1 = 1'b0;
    chk("rd_ready", ready1, 1'b0);
    chk("rd_wen", wen1, 1'b0);
    chk("rd_raddr_top", rat1, 1'b1);
    chk("rd_raddr_bot", rab1, 2'd2);
    @(negedge clk);
    chk("enq_empty_done", done1, 1'b1);
    chk("enq_empty_code", code1, 2'd0);
    chk("enq_empty_wen", wen1, 1'b1);
    chk("enq_empty_waddr", wat1, 1'b1);
    chk("enq_empty_wdata", wdata1, ent(1'b1, 4'd5, 8'd5));
    @(negedge clk);
    chk("idle_done", done1, 1'b0);
    chk("idle_wdata", wdata1, 13'h0);

    // Enqueue push-down: larger value stays, smaller goes to roomier child
    r_top = ent(1'b1, 4'd6, 8'd9); r_bot_l = ent(1'b1, 4'd2, 8'd1); r_bot_r = ent(1'b1, 4'd3, 8'd2);
    issue(2'd1, 1'b0, 8'd12);
    chk("enq_push_wdata", wdata1, ent(1'b1, 4'd5, 8'd12));
    chk("enq_push_nval", nval1, 8'd9);
    chk("enq_push_npos", npos1, 2'd1);
    chk("enq_push_nop", nop1, 2'd1);
    chk("enq_push_code", code1, 2'd1);
    chk("leaf_enq_code", codeL, 2'd2);
    chk("leaf_enq_wen", wenL, 1'b0);

    // Enqueue capacity tie goes left, smaller incoming value pushed down
    r_top = ent(1'b1, 4'd3, 8'd9); r_bot_l = ent(1'b1, 4'd2, 8'd1); r_bot_r = ent(1'b1, 4'd2, 8'd2);
    issue(2'd1, 1'b1, 8'd4);
    chk("enq_tie_wdata", wdata1, ent(1'b1, 4'd2, 8'd9));
    chk("enq_tie_nval", nval1, 8'd4);
    chk("enq_tie_npos", npos1, 2'd2);

    // Full
    r_top = ent(1'b1, 4'd0, 8'd7);
    issue(2'd1, 1'b0, 8'd3);
    chk("full_code", code1, 2'd2);
    chk("full_wen", wen1, 1'b0);

    // Empty
    r_top = ent(1'b0, 4'd3, 8'd0);
    issue(2'd2, 1'b0, 8'd0);
    chk("empty_code", code1, 2'd3);
    chk("empty_wen", wen1, 1'b0);
    chk("empty_out", oval1, 8'd0);

    // Dequeue with promotion, value tie goes left
    r_top = ent(1'b1, 4'd0, 8'd20); r_bot_l = ent(1'b1, 4'd1, 8'd8); r_bot_r = ent(1'b1, 4'd1, 8'd8);
    issue(2'd2, 1'b1, 8'd0);
    chk("deq_out", oval1, 8'd20);
    chk("deq_wdata", wdata1, ent(1'b1, 4'd1, 8'd8));
    chk("deq_npos", npos1, 2'd2);
    chk("deq_nop", nop1, 2'd2);
    chk("deq_code", code1, 2'd1);
    chk("leaf_deq_wdata", wdataL, ent(1'b0, 4'd1, 8'd0));
    chk("leaf_deq_code", codeL, 2'd0);

    // Dequeue: inactive left child never wins even with a larger stale value
    r_top = ent(1'b1, 4'd0, 8'd40); r_bot_l = ent(1'b0, 4'd1, 8'd50); r_bot_r = ent(1'b1, 4'd0, 8'd7);
    issue(2'd2, 1'b0, 8'd0);
    chk("deq_r_wdata", wdata1, ent(1'b1, 4'd1, 8'd7));
    chk("deq_r_npos", npos1, 2'd1);

    // Dequeue of the last entry in the subtree
    r_top = ent(1'b1, 4'd4, 8'd33); r_bot_l = ent(1'b0, 4'd2, 8'd0); r_bot_r = ent(1'b0, 4'd2, 8'd0);
    issue(2'd2, 1'b0, 8'd0);
    chk("deq_last_wdata", wdata1, ent(1'b0, 4'd5, 8'd0));
    chk("deq_last_code", code1, 2'd0);
    chk("deq_last_out", oval1, 8'd33);

    // Replace, incoming value smaller than the active child
    r_top = ent(1'b1, 4'd2, 8'd20); r_bot_l = ent(1'b1, 4'd0, 8'd10); r_bot_r = ent(1'b0, 4'd0, 8'd0);
    issue(2'd3, 1'b0, 8'd3);
    chk("repl_out", oval1, 8'd20);
    chk("repl_wdata", wdata1, ent(1'b1, 4'd2, 8'd10));
    chk("repl_nval", nval1, 8'd3);
    chk("repl_nop", nop1, 2'd3);
    chk("repl_code", code1, 2'd1);

    // Replace, incoming value stays at this level
    issue(2'd3, 1'b0, 8'd15);
    chk("repl2_wdata", wdata1, ent(1'b1, 4'd2, 8'd15));
    chk("repl2_code", code1, 2'd0);
    chk("repl2_out", oval1, 8'd20);

    // Back-to-back issue on RD_LAT=3: done every 4 cycles
    r_top = ent(1'b0, 4'd6, 8'd0);
    @(negedge clk);
    start3 = 1'b1; op = 2'd1; start_pos = 1'b0; in_val = 8'd1;
    for (int unsigned k = 1; k <= 12; k++) begin
      @(negedge clk);
      chk("b2b_done", done3, (k % 4 == 0));
    end
    start3 = 1'b0;
    @(negedge clk);
    chk("b2b_idle_ready", ready3, 1'b1);

    // Reset during RD aborts the operation
    @(negedge clk);
    start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    chk("abort_rd_ready", ready3, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_ready", ready3, 1'b1);
    chk("abort_wen", wen3, 1'b0);
    @(negedge clk); rst_n = 1'b1;
    for (int unsigned k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("abort_no_wen", wen3, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
